// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants and state encoding for the pipeline stall controller.
package pipeline_stall_controller_pkg;

  typedef enum logic {
    STATE_RUN   = 1'b0,
    STATE_FLUSH = 1'b1
  } state_t;

  localparam int DEFAULT_FLUSH_CYCLES = 1;
  localparam int DEFAULT_MAX_STALL    = 4;
  localparam int DEFAULT_CNT_W        = 16;

endpackage

// File: rtl/pipeline_stall_controller_perf_counter.sv
// Free-running event counter: increments on enable, wraps, cleared by reset.
module perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count one event per enabled cycle, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: turns hazard, branch and memory-wait status
// into pipeline register enables, sequences multi-cycle flushes, watches for
// runaway stalls and counts stall/flush/freeze cycles.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter int MAX_STALL    = DEFAULT_MAX_STALL,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             br_taken,
  input  logic             is_jmp,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             exe_mem_write,
  output logic             mem_wb_write,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t           state;
  logic [2:0]       flush_left;
  logic [RUN_W-1:0] stall_run;

  logic redirect;
  logic hazard_cycle;
  logic flush_cycle;

  // A branch/jump only redirects from RUN; in FLUSH the ID instruction is wrong-path.
  assign redirect     = (br_taken || is_jmp) && (state == STATE_RUN);
  assign hazard_cycle = !mem_stall && hazard_detected;
  assign flush_cycle  = !mem_stall && !hazard_detected && (redirect || state == STATE_FLUSH);

  // Zero-latency control decode in priority order: reset, freeze, hazard, flush, idle.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    exe_mem_write = 1'b1;
    mem_wb_write  = 1'b1;
    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
      exe_mem_write = 1'b0;
      mem_wb_write  = 1'b0;
    end else if (mem_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      exe_mem_write = 1'b0;
      mem_wb_write  = 1'b0;
    end else if (hazard_detected) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else if (flush_cycle) begin
      if_id_flush = 1'b1;
    end
  end

  // Flush sequencing FSM plus the consecutive-stall watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STATE_RUN;
      flush_left    <= 3'd0;
      stall_run     <= '0;
      stall_timeout <= 1'b0;
    end else if (mem_stall) begin
      state      <= state;
      flush_left <= flush_left;
      stall_run  <= stall_run;
    end else if (hazard_detected) begin
      if (stall_run != RUN_SAT) begin
        stall_run <= stall_run + 1'b1;
      end
      if (stall_run >= RUN_SAT - 1'b1) begin
        stall_timeout <= 1'b1;
      end
    end else begin
      stall_run <= '0;
      if (state == STATE_FLUSH) begin
        flush_left <= flush_left - 3'd1;
        if (flush_left == 3'd1) begin
          state <= STATE_RUN;
        end
      end else if (redirect && FLUSH_CYCLES > 1) begin
        state      <= STATE_FLUSH;
        flush_left <= FLUSH_INIT;
      end
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hazard_cycle),
    .count (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_cycle),
    .count (flush_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_freeze_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_stall),
    .count (freeze_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller with FLUSH_CYCLES=3, MAX_STALL=4.
// Control vector order: {pc_write, if_id_write, if_id_flush, id_exe_bubble,
// exe_mem_write, mem_wb_write}; counters are the values seen during the cycle.
module tb_pipeline_stall_controller;

  localparam logic [5:0] C_IDLE   = 6'b110011;
  localparam logic [5:0] C_HAZARD = 6'b000111;
  localparam logic [5:0] C_FLUSH  = 6'b111011;
  localparam logic [5:0] C_FREEZE = 6'b000000;
  localparam logic [5:0] C_RESET  = 6'b001100;

  typedef struct {
    int          idx;
    logic [5:0]  ctrl;
    logic        timeout;
    logic [15:0] s;
    logic [15:0] f;
    logic [15:0] z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hazard_detected = 1'b0;
  logic br_taken = 1'b0;
  logic is_jmp = 1'b0;
  logic mem_stall = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_exe_bubble, exe_mem_write, mem_wb_write;
  logic stall_timeout;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   vec_idx = 0;

  pipeline_stall_controller #(
    .FLUSH_CYCLES (3),
    .MAX_STALL    (4),
    .CNT_W        (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_detected (hazard_detected),
    .br_taken        (br_taken),
    .is_jmp          (is_jmp),
    .mem_stall       (mem_stall),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_exe_bubble   (id_exe_bubble),
    .exe_mem_write   (exe_mem_write),
    .mem_wb_write    (mem_wb_write),
    .stall_timeout   (stall_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .freeze_cnt      (freeze_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ctrlNow();
    return {pc_write, if_id_write, if_id_flush, id_exe_bubble, exe_mem_write, mem_wb_write};
  endfunction

  // One comparison: counts it and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the expected response.
  task automatic applyStimulus(input logic h, input logic b, input logic j, input logic m,
                               input logic [5:0] ctrl, input logic to,
                               input int s, input int f, input int z);
    exp_t e;
    @(posedge clk);
    #1;
    hazard_detected = h;
    br_taken        = b;
    is_jmp          = j;
    mem_stall       = m;
    e.idx     = vec_idx;
    e.ctrl    = ctrl;
    e.timeout = to;
    e.s       = 16'(s);
    e.f       = 16'(f);
    e.z       = 16'(z);
    exp_q.push_back(e);
    vec_idx++;
  endtask

  task automatic checkResetValues(input int idx);
    checkOutput("reset_ctrl", idx, 32'(ctrlNow()), 32'(C_RESET));
    checkOutput("reset_timeout", idx, 32'(stall_timeout), 32'd0);
    checkOutput("reset_stall_cnt", idx, 32'(stall_cnt), 32'd0);
    checkOutput("reset_flush_cnt", idx, 32'(flush_cnt), 32'd0);
    checkOutput("reset_freeze_cnt", idx, 32'(freeze_cnt), 32'd0);
  endtask

  // Monitor: the DUT presents a response every cycle out of reset; compare it on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("ctrl", e.idx, 32'(ctrlNow()), 32'(e.ctrl));
        checkOutput("stall_timeout", e.idx, 32'(stall_timeout), 32'(e.timeout));
        checkOutput("stall_cnt", e.idx, 32'(stall_cnt), 32'(e.s));
        checkOutput("flush_cnt", e.idx, 32'(flush_cnt), 32'(e.f));
        checkOutput("freeze_cnt", e.idx, 32'(freeze_cnt), 32'(e.z));
      end
    end
  end

  initial begin
    int wait_cycles;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    checkResetValues(-1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    applyStimulus(0, 0, 0, 0, C_IDLE, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, C_IDLE, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, C_IDLE, 0, 0, 0, 0);

    // Hazard with a concurrent taken branch: branch ignored.
    applyStimulus(1, 1, 0, 0, C_HAZARD, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, C_HAZARD, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, C_IDLE,   0, 2, 0, 0);

    // Branch pulse: exactly three flush cycles; a branch seen inside FLUSH is ignored.
    applyStimulus(0, 1, 0, 0, C_FLUSH, 0, 2, 0, 0);
    applyStimulus(0, 1, 0, 0, C_FLUSH, 0, 2, 1, 0);
    applyStimulus(0, 0, 0, 0, C_FLUSH, 0, 2, 2, 0);
    applyStimulus(0, 0, 0, 0, C_IDLE,  0, 2, 3, 0);

    // Branch then a two-cycle memory freeze in the middle of the flush.
    applyStimulus(0, 1, 0, 0, C_FLUSH,  0, 2, 3, 0);
    applyStimulus(0, 0, 0, 1, C_FREEZE, 0, 2, 4, 0);
    applyStimulus(1, 1, 0, 1, C_FREEZE, 0, 2, 4, 1);
    applyStimulus(0, 0, 0, 0, C_FLUSH,  0, 2, 4, 2);
    applyStimulus(0, 0, 0, 0, C_FLUSH,  0, 2, 5, 2);
    applyStimulus(0, 0, 0, 0, C_IDLE,   0, 2, 6, 2);

    // Five consecutive hazard cycles trip the watchdog; it stays set.
    applyStimulus(1, 0, 0, 0, C_HAZARD, 0, 2, 6, 2);
    applyStimulus(1, 0, 0, 0, C_HAZARD, 0, 3, 6, 2);
    applyStimulus(1, 0, 0, 0, C_HAZARD, 0, 4, 6, 2);
    applyStimulus(1, 0, 0, 0, C_HAZARD, 0, 5, 6, 2);
    applyStimulus(1, 0, 0, 0, C_HAZARD, 0, 6, 6, 2);
    applyStimulus(0, 0, 0, 0, C_IDLE,   1, 7, 6, 2);
    applyStimulus(0, 0, 0, 0, C_IDLE,   1, 7, 6, 2);

    // Jump also starts a three-cycle flush.
    applyStimulus(0, 0, 1, 0, C_FLUSH, 1, 7, 6, 2);
    applyStimulus(0, 0, 0, 0, C_FLUSH, 1, 7, 7, 2);
    applyStimulus(0, 0, 0, 0, C_FLUSH, 1, 7, 8, 2);
    applyStimulus(0, 0, 0, 0, C_IDLE,  1, 7, 9, 2);

    // Reset asserted in the middle of a flush.
    applyStimulus(0, 1, 0, 0, C_FLUSH, 1, 7, 9, 2);
    applyStimulus(0, 0, 0, 0, C_FLUSH, 1, 7, 10, 2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues(-2);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, C_IDLE, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, C_IDLE, 0, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
